cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath for the phase-1 processor.
- Contains a 16-entry register file plus PC, IR, MAR, MDR, Y, HI, LO and a 64-bit Z register, all around one internal 32-bit bus, with a combinational ALU.
- An external control unit (a testbench in phase 1) sequences it with one-hot register-in/out strobes and a 4-bit ALU opcode.

Parameters:
- WIDTH, 32, data/bus width.
- NREGS, 16, number of general registers R0..R15.

Ports:
- clock in 1: single system clock; all state changes on the rising edge.
- clear in 1: synchronous active-high reset.
- A in 32: external input-port word, consumed by ALU op IN.
- RegisterImmediate in 32: sign-extended immediate, consumed by ALU op ADDI.
- Read in 1: MDR source select; 1 = Mdatain, 0 = bus.
- Mdatain in 32: memory read data.
- ALUop in 4: ALU operation select.
- Rin in 16: per-register load enables (bit i loads Ri from the bus).
- Rout in 16: per-register bus-drive selects.
- MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin in 1 each: register load enables.
- PCout, MDRout, HIout, LOout, Zhighout, Zlowout in 1 each: bus-drive selects.
- MARout out 32: MAR contents (memory address).
- IRout out 32: IR contents (to control unit).
- Yout out 32: Y contents (observation).

Behaviour:
- Reset: when clear=1 at a rising edge, every register (R0-R15, PC, IR, MAR, MDR, Y, HI, LO, Z[63:0]) becomes 0. Reset overrides all load enables. MARout, IRout and Yout read 0 in the cycle after reset.
- Bus: combinational mux.
  - Priority when several selects are high: Zhighout > Zlowout > HIout > LOout > MDRout > PCout > R0 > R1 > ... > R15.
  - No select high -> bus = 0.
  - Control is expected to assert one select at a time; the priority only makes the result deterministic.
- Loads: each register with its enable high captures its input at the rising edge; a register with its enable low holds.
  - Ri, PC, IR, MAR, Y, HI, LO load from the bus.
  - MDR loads Mdatain when Read=1, otherwise the bus.
  - Zlowin loads Z[31:0] from ALU result[31:0]; Zhighin loads Z[63:32] from ALU result[63:32]. The two are independent.
- Read-before-write: a register that drives the bus and is loaded in the same cycle captures the pre-edge value on the bus. No combinational loops exist (Z is registered).
- ALU: operand a = Y, operand b = bus, result 64 bits. Result[63:32] = 0 unless stated otherwise. Opcodes:
  - 0 OR; 1 AND.
  - 2 ADD; 3 SUB (a-b). Both wrap modulo 2^32.
  - 4 MUL: signed a*b, full 64 bits.
  - 5 DIV: signed; low = quotient truncated toward zero, high = remainder. If b=0: low = 0xFFFFFFFF, high = a.
  - 6 SHR (logical), 7 SHRA (arithmetic), 8 SHL: a shifted by b[4:0].
  - 9 ROR, 10 ROL: a rotated by b[4:0].
  - 11 NEG = -b; 12 NOT = ~b.
  - 13 ADDI = a + RegisterImmediate.
  - 14 IN = A.
  - 15 INC = b + 1 (PC increment).
- Latency: each register transfer takes one clock. A two-operand operation takes three cycles: Rout->Yin, Rout+ALUop->Zlowin, Zlowout->Rin.

Decomposition:
- Shared package cpu_pkg: WIDTH, NREGS, and ALU opcode localparams (ALU_OR=0 ... ALU_INC=15).
- One sub-module, cpu_alu: purely combinational (a, b, imm, inport, op -> 64-bit result).
- Bus mux and registers are inline in cpu_datapath.

Test Plan:
- OR: Mdatain 0x34 with Read+MDRin, then MDRout+Rin[5]; likewise 0x45 into R6. Then Rout[5]+Yin, then Rout[6]+ALUop 0+Zlowin, then Zlowout+Rin[2] -> R2=0x00000075. Drive Rout[2] -> bus 0x75.
- Fetch after clear: PCout+MARin+ALUop 15+Zlowin, then Zlowout+PCin+Read+MDRin (Mdatain 0xA5A5A5A5), then MDRout+IRin -> MARout=0, PC=1, IRout=0xA5A5A5A5.
- MUL/DIV: Y=0xFFFFFFFE(-2), bus=3.
  - MUL with both Z enables -> Z=0xFFFFFFFF_FFFFFFFA.
  - DIV with Y=7, bus=2 -> Zlow=3, Zhigh=1.
  - DIV with bus=0 -> Zlow=0xFFFFFFFF, Zhigh=7.
- Shifts/rotates: Y=0x80000001, bus=4 -> SHR 0x08000000, SHRA 0xF8000000, SHL 0x00000010, ROR 0x18000000, ROL 0x00000018.
- Reset mid-operation: load R3=0x1234 and Y=5. Assert clear together with Rin[3] and bus=0x99 -> R3=0 and Y=0 next cycle, and all outputs read 0.
- Bus priority / MDR select: Zlowout and Rout[1] high together -> bus = Zlow. MDRin with Read=0 while R1 (0x55) drives -> MDR=0x55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and ALU opcode encodings for the single-bus CPU datapath.
package cpu_pkg;
    localparam int WIDTH = 32;
    localparam int NREGS = 16;

    localparam logic [3:0] ALU_OR   = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_MUL  = 4'd4;
    localparam logic [3:0] ALU_DIV  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_ROR  = 4'd9;
    localparam logic [3:0] ALU_ROL  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;
    localparam logic [3:0] ALU_ADDI = 4'd13;
    localparam logic [3:0] ALU_IN   = 4'd14;
    localparam logic [3:0] ALU_INC  = 4'd15;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: a = Y, b = bus; 64-bit result, upper half used by MUL/DIV only.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   imm,
    input  logic [WIDTH-1:0]   inport,
    input  logic [3:0]         op,
    output logic [2*WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);

    // Divide-by-zero and the single overflowing quotient are pinned to fixed answers.
    function automatic logic [2*WIDTH-1:0] sdiv(input logic signed [WIDTH-1:0] n,
                                                 input logic signed [WIDTH-1:0] d);
        logic signed [WIDTH-1:0] q;
        logic signed [WIDTH-1:0] r;
        if (d == '0) begin
            q = '1;
            r = n;
        end else if (n == {1'b1, {(WIDTH-1){1'b0}}} && d == '1) begin
            q = n;
            r = '0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    logic signed [WIDTH-1:0]   sa;
    logic signed [WIDTH-1:0]   sb;
    logic signed [2*WIDTH-1:0] sa_w;
    logic signed [2*WIDTH-1:0] sb_w;
    logic signed [2*WIDTH-1:0] prod;
    logic [SHW-1:0]            sh;
    logic [SHW:0]              rsh;

    assign sa   = $signed(a);
    assign sb   = $signed(b);
    assign sa_w = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb_w = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod = sa_w * sb_w;
    assign sh   = b[SHW-1:0];
    assign rsh  = (SHW+1)'(WIDTH) - {1'b0, sh};

    always_comb begin
        result = '0;
        case (op)
            ALU_OR:   result[WIDTH-1:0] = a | b;
            ALU_AND:  result[WIDTH-1:0] = a & b;
            ALU_ADD:  result[WIDTH-1:0] = a + b;
            ALU_SUB:  result[WIDTH-1:0] = a - b;
            ALU_MUL:  result = prod;
            ALU_DIV:  result = sdiv(sa, sb);
            ALU_SHR:  result[WIDTH-1:0] = a >> sh;
            ALU_SHRA: result[WIDTH-1:0] = sa >>> sh;
            ALU_SHL:  result[WIDTH-1:0] = a << sh;
            ALU_ROR:  result[WIDTH-1:0] = (a >> sh) | (a << rsh);
            ALU_ROL:  result[WIDTH-1:0] = (a << sh) | (a >> rsh);
            ALU_NEG:  result[WIDTH-1:0] = '0 - b;
            ALU_NOT:  result[WIDTH-1:0] = ~b;
            ALU_ADDI: result[WIDTH-1:0] = a + imm;
            ALU_IN:   result[WIDTH-1:0] = inport;
            ALU_INC:  result[WIDTH-1:0] = b + WIDTH'(1);
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux and ALU/Z stage.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] RegisterImmediate,
    input  logic             Read,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [3:0]       ALUop,
    input  logic [NREGS-1:0] Rin,
    input  logic [NREGS-1:0] Rout,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             MDRin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             Zhighin,
    input  logic             Zlowin,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    output logic [WIDTH-1:0] MARout,
    output logic [WIDTH-1:0] IRout,
    output logic [WIDTH-1:0] Yout
);
    logic [WIDTH-1:0]   r [NREGS];
    logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo;
    logic [2*WIDTH-1:0] z;
    logic [2*WIDTH-1:0] alu_result;
    logic [WIDTH-1:0]   bus;

    // Later assignments win, so R0 beats R15 and Zhighout beats everything.
    always_comb begin
        bus = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (Rout[i]) bus = r[i];
        end
        if (PCout)    bus = pc;
        if (MDRout)   bus = mdr;
        if (LOout)    bus = lo;
        if (HIout)    bus = hi;
        if (Zlowout)  bus = z[WIDTH-1:0];
        if (Zhighout) bus = z[2*WIDTH-1:WIDTH];
    end

    cpu_alu u_alu (
        .a      (y),
        .b      (bus),
        .imm    (RegisterImmediate),
        .inport (A),
        .op     (ALUop),
        .result (alu_result)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
            z   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (Rin[i]) r[i] <= bus;
            end
            if (PCin)    pc  <= bus;
            if (IRin)    ir  <= bus;
            if (MARin)   mar <= bus;
            if (Yin)     y   <= bus;
            if (HIin)    hi  <= bus;
            if (LOin)    lo  <= bus;
            if (MDRin)   mdr <= Read ? Mdatain : bus;
            if (Zlowin)  z[WIDTH-1:0]       <= alu_result[WIDTH-1:0];
            if (Zhighin) z[2*WIDTH-1:WIDTH] <= alu_result[2*WIDTH-1:WIDTH];
        end
    end

    assign MARout = mar;
    assign IRout  = ir;
    assign Yout   = y;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: stimulus queues expected outputs, a monitor compares them.
module tb_cpu_datapath;
    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A, RegisterImmediate, Mdatain;
    logic        Read;
    logic [3:0]  ALUop;
    logic [15:0] Rin, Rout;
    logic        MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin;
    logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout;
    logic [31:0] MARout, IRout, Yout;

    cpu_datapath dut (
        .clock(clock), .clear(clear), .A(A), .RegisterImmediate(RegisterImmediate),
        .Read(Read), .Mdatain(Mdatain), .ALUop(ALUop), .Rin(Rin), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MARout(MARout), .IRout(IRout), .Yout(Yout)
    );

    always #5 clock = ~clock;

    // sel: 0 = MARout, 1 = IRout, 2 = Yout
    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        mc;
    logic [31:0] act;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            mc = sb_q.pop_front();
            case (mc.sel)
                0:       act = MARout;
                1:       act = IRout;
                default: act = Yout;
            endcase
            checks++;
            if (act !== mc.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mc.name, act, mc.exp);
            end
        end
    end

    task automatic expect_out(input string n, input int unsigned s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        sb_q.push_back(c);
        checks++;
        if (s == 0) begin
            if (MARout !== e) begin
                errors++;
                $display("FAIL %s (now): MARout 0x%08h expected 0x%08h", n, MARout, e);
            end
        end else if (s == 1) begin
            if (IRout !== e) begin
                errors++;
                $display("FAIL %s (now): IRout 0x%08h expected 0x%08h", n, IRout, e);
            end
        end else begin
            if (Yout !== e) begin
                errors++;
                $display("FAIL %s (now): Yout 0x%08h expected 0x%08h", n, Yout, e);
            end
        end
    endtask

    task automatic idle();
        clear = 0; Read = 0; ALUop = 4'd0; Rin = '0; Rout = '0;
        MARin = 0; PCin = 0; IRin = 0; Yin = 0; MDRin = 0; HIin = 0; LOin = 0;
        Zhighin = 0; Zlowin = 0; PCout = 0; MDRout = 0; HIout = 0; LOout = 0;
        Zhighout = 0; Zlowout = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        cyc();
    endtask

    task automatic load_reg(input int i, input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; Rin[i] = 1'b1;
        cyc();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDRout = 1; Yin = 1;
        cyc();
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] bval);
        load_mdr(bval);
        MDRout = 1; ALUop = op; Zlowin = 1; Zhighin = 1;
        cyc();
    endtask

    task automatic check_z(input string n, input logic [31:0] lo_e, input logic [31:0] hi_e);
        Zlowout = 1; MARin = 1;
        cyc();
        expect_out({n, "_zlow"}, 0, lo_e);
        Zhighout = 1; MARin = 1;
        cyc();
        expect_out({n, "_zhigh"}, 0, hi_e);
    endtask

    logic [3:0]  tab_op  [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8,
                                  4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [31:0] tab_exp [14] = '{32'h80000005, 32'h00000000, 32'h80000005, 32'h7FFFFFFD,
                                  32'h08000000, 32'hF8000000, 32'h00000010, 32'h18000000,
                                  32'h00000018, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h80000000,
                                  32'hDEADBEEF, 32'h00000005};

    initial begin
        A = 32'hDEADBEEF; RegisterImmediate = 32'hFFFFFFFF; Mdatain = '0;
        idle();
        clear = 1;
        cyc();
        expect_out("reset_mar", 0, 32'h0);
        expect_out("reset_ir",  1, 32'h0);
        expect_out("reset_y",   2, 32'h0);

        // Fetch: MAR <= PC, Z <= PC+1, then PC <= Z and MDR <= memory, then IR <= MDR
        PCout = 1; MARin = 1; ALUop = 4'd15; Zlowin = 1;
        cyc();
        expect_out("fetch_mar", 0, 32'h0);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'hA5A5A5A5;
        cyc();
        MDRout = 1; IRin = 1;
        cyc();
        expect_out("fetch_ir", 1, 32'hA5A5A5A5);
        PCout = 1; MARin = 1;
        cyc();
        expect_out("fetch_pc", 0, 32'h1);

        // OR of R5 and R6 into R2
        load_reg(5, 32'h34);
        load_reg(6, 32'h45);
        Rout[5] = 1; Yin = 1;
        cyc();
        expect_out("or_y", 2, 32'h34);
        Rout[6] = 1; ALUop = 4'd0; Zlowin = 1;
        cyc();
        Zlowout = 1; Rin[2] = 1;
        cyc();
        Rout[2] = 1; MARin = 1;
        cyc();
        expect_out("or_r2", 0, 32'h75);
        Rout[2] = 1; Yin = 1;
        cyc();
        expect_out("or_bus", 2, 32'h75);

        // MUL / DIV
        load_y(32'hFFFFFFFE);
        run_op(4'd4, 32'd3);
        check_z("mul", 32'hFFFFFFFA, 32'hFFFFFFFF);
        load_y(32'd7);
        run_op(4'd5, 32'd2);
        check_z("div", 32'd3, 32'd1);
        run_op(4'd5, 32'd0);
        check_z("div0", 32'hFFFFFFFF, 32'd7);
        load_y(32'hFFFFFFF9);
        run_op(4'd5, 32'd2);
        check_z("divneg", 32'hFFFFFFFD, 32'hFFFFFFFF);

        // Remaining opcodes with Y=0x80000001, bus=4
        load_y(32'h80000001);
        for (int k = 0; k < 14; k++) begin
            run_op(tab_op[k], 32'd4);
            check_z($sformatf("op%0d", tab_op[k]), tab_exp[k], 32'h0);
        end

        // Bus priority (Zlow holds 5 from INC) and MDR bus path
        load_reg(1, 32'h55);
        Zlowout = 1; Rout[1] = 1; MARin = 1;
        cyc();
        expect_out("prio_zlow", 0, 32'h5);
        Rout[1] = 1; MDRin = 1; Read = 0; Mdatain = 32'hFFFF0000;
        cyc();
        MDRout = 1; MARin = 1;
        cyc();
        expect_out("mdr_bus", 0, 32'h55);

        // Clear overriding loads mid-operation
        load_reg(3, 32'h1234);
        load_y(32'd5);
        load_mdr(32'h99);
        clear = 1; Rin[3] = 1; MDRout = 1; Yin = 1; MARin = 1; IRin = 1;
        cyc();
        expect_out("clr_mar", 0, 32'h0);
        expect_out("clr_ir",  1, 32'h0);
        expect_out("clr_y",   2, 32'h0);
        Rout[3] = 1; MARin = 1;
        cyc();
        expect_out("clr_r3", 0, 32'h0);
        MDRout = 1; MARin = 1;
        cyc();
        expect_out("clr_mdr", 0, 32'h0);

        repeat (4) @(posedge clock);
        while (sb_q.size() > 0) begin
            mc = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared, expected 0x%08h", mc.name, mc.exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
